// File: rtl/sram_axil_responder.sv
//------------------------------------------------------------------------------
// sram_axil_responder : AXI-Lite responder serialising accesses to an async SRAM.
// Optional macro SRAM_AXIL_RR_ARB_EN selects round-robin read/write arbitration.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_axil_responder #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [AXI_ADDR_WIDTH-1:0]     sram_addr,
  output logic [AXI_DATA_WIDTH-1:0]     sram_data_o,
  input  logic [AXI_DATA_WIDTH-1:0]     sram_data_i,
  output logic                          sram_data_oe,
  output logic                          sram_ce_n,
  output logic                          sram_oe_n,
  output logic                          sram_we_n
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    RRESP = 3'd2,
    WR    = 3'd3,
    WHOLD = 3'd4,
    BRESP = 3'd5
  } state_t;

  state_t                      state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                        rd_req, wr_req;
  logic                        grant_rd, grant_wr;
  logic                        unused_wstrb;

  assign unused_wstrb = ^s_axi_wstrb;

  // A write needs both AW and W present; neither is accepted on its own.
  assign rd_req = s_axi_arvalid;
  assign wr_req = s_axi_awvalid && s_axi_wvalid;

`ifdef SRAM_AXIL_RR_ARB_EN
  logic last_grant_q, last_grant_d;  // 1 = last grant was a write

  assign grant_wr = wr_req && (!rd_req || !last_grant_q);
  assign grant_rd = rd_req && !grant_wr;

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE) begin
      if (grant_wr)      last_grant_d = 1'b1;
      else if (grant_rd) last_grant_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) last_grant_q <= 1'b0;
    else        last_grant_q <= last_grant_d;
  end
`else
  assign grant_rd = rd_req;
  assign grant_wr = wr_req && !rd_req;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    s_axi_arready = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_bvalid  = 1'b0;
    sram_ce_n     = 1'b1;
    sram_oe_n     = 1'b1;
    sram_we_n     = 1'b1;
    sram_data_oe  = 1'b0;
    case (state_q)
      IDLE: begin
        s_axi_arready = reset && grant_rd;
        s_axi_awready = reset && grant_wr;
        s_axi_wready  = reset && grant_wr;
        if (grant_rd) begin
          state_d = RD;
          addr_d  = s_axi_araddr;
        end else if (grant_wr) begin
          state_d = WR;
          addr_d  = s_axi_awaddr;
          wdata_d = s_axi_wdata;
        end
      end
      RD: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        rdata_d   = sram_data_i;
        state_d   = RRESP;
      end
      RRESP: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) state_d = IDLE;
      end
      WR: begin
        sram_ce_n    = 1'b0;
        sram_we_n    = 1'b0;
        sram_data_oe = 1'b1;
        state_d      = WHOLD;
      end
      // WE has risen; keep chip selected and data driven for hold time.
      WHOLD: begin
        sram_ce_n    = 1'b0;
        sram_data_oe = 1'b1;
        state_d      = BRESP;
      end
      BRESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign sram_addr   = addr_q;
  assign sram_data_o = wdata_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = 2'b00;
  assign s_axi_bresp = 2'b00;

endmodule

`default_nettype wire
